// File: rtl/mod_counter_chain_pkg.sv
// Shared constants and helpers for the modulo counter chain.
// Direction encoding and packed digit-field indexing live here.
package mod_counter_chain_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // LSB position of digit idx inside a packed DIGITS*WIDTH vector.
    function automatic int digit_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mod_counter_chain_if.sv
// Control/data bundle for mod_counter_chain; master drives controls, slave owns the count.
interface mod_counter_chain_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 4
);
    logic                      en;
    logic                      up;
    logic                      clr;
    logic                      load;
    logic [DIGITS*WIDTH-1:0]   load_val;
    logic [DIGITS*WIDTH-1:0]   out;
    logic                      tc;
    logic                      wrap;

    modport master (
        output en, up, clr, load, load_val,
        input  out, tc, wrap
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output out, tc, wrap
    );
endinterface

// File: rtl/mod_counter_chain_counter_digit.sv
// One modulo-MAX digit: clear > load (saturating) > step, wrapping in both directions.
module counter_digit
    import mod_counter_chain_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dig,
    output logic [WIDTH-1:0] dig,
    output logic             at_max,
    output logic             at_zero
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] dig_d, dig_q;

    assign at_max  = (dig_q == TOP);
    assign at_zero = (dig_q == '0);
    assign dig     = dig_q;

    always_comb begin
        dig_d = dig_q;
        if (clr) begin
            dig_d = '0;
        end else if (load) begin
            // Out-of-range load fields clamp so no illegal value is ever stored.
            dig_d = (load_dig > TOP) ? TOP : load_dig;
        end else if (step) begin
            if (up == DIR_UP) dig_d = at_max  ? '0  : dig_q + 1'b1;
            else              dig_d = at_zero ? TOP : dig_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dig_q <= '0;
        else     dig_q <= dig_d;
    end
endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of DIGITS modulo-MAX digits with a combinational carry/borrow chain,
// zero-latency terminal count and a registered wrap strobe.
module mod_counter_chain
    import mod_counter_chain_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 4,
    parameter int MAX    = 10
) (
    input  logic                clk,
    input  logic                rst,
    mod_counter_chain_if.slave  bus
);
    logic [DIGITS-1:0]            at_max;
    logic [DIGITS-1:0]            at_zero;
    logic [DIGITS-1:0]            step;
    logic [DIGITS-1:0][WIDTH-1:0] dig;
    logic                         wrap_d, wrap_q;

    // Digit i steps only when every lower digit is at its rollover value.
    always_comb begin
        step    = '0;
        step[0] = bus.en;
        for (int i = 1; i < DIGITS; i++) begin
            step[i] = step[i-1] & ((bus.up == DIR_UP) ? at_max[i-1] : at_zero[i-1]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        counter_digit #(
            .WIDTH (WIDTH),
            .MAX   (MAX)
        ) u_dig (
            .clk      (clk),
            .rst      (rst),
            .step     (step[g]),
            .up       (bus.up),
            .clr      (bus.clr),
            .load     (bus.load),
            .load_dig (bus.load_val[digit_lsb(g, WIDTH) +: WIDTH]),
            .dig      (dig[g]),
            .at_max   (at_max[g]),
            .at_zero  (at_zero[g])
        );
    end

    assign bus.out = dig;
    assign bus.tc  = bus.en & ((bus.up == DIR_UP) ? (&at_max) : (&at_zero));

    // clr/load override the step, so a high tc in that cycle must not strobe wrap.
    always_comb begin
        wrap_d = bus.tc & ~bus.clr & ~bus.load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end

    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_mod_counter_chain.sv
// Self-checking bench: two chains (2x mod-10, 3x mod-16) against an integer-valued model.
module tb_mod_counter_chain;
    localparam int AD = 2, AW = 4, AM = 10;
    localparam int BD = 3, BW = 4, BM = 16;
    localparam int AMOD = 100, BMOD = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_counter_chain_if #(.DIGITS(AD), .WIDTH(AW)) a_if ();
    mod_counter_chain_if #(.DIGITS(BD), .WIDTH(BW)) b_if ();

    mod_counter_chain #(.DIGITS(AD), .WIDTH(AW), .MAX(AM)) u_a (
        .clk (clk), .rst (rst), .bus (a_if.slave));
    mod_counter_chain #(.DIGITS(BD), .WIDTH(BW), .MAX(BM)) u_b (
        .clk (clk), .rst (rst), .bus (b_if.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: the chain's value as a plain integer in [0, MAX**DIGITS).
    int a_v, b_v;
    bit a_w, b_w;

    // Stimulus for the next tick.
    bit          a_en, a_up, a_clr, a_load;
    logic [31:0] a_lv;
    bit          b_en, b_up, b_clr, b_load;
    logic [31:0] b_lv;

    function automatic int pk2int(input logic [31:0] p, input int d, input int w, input int m);
        int v = 0;
        for (int i = d - 1; i >= 0; i--) begin
            int f;
            f = int'((p >> (i * w)) & ((32'd1 << w) - 32'd1));
            if (f >= m) f = m - 1;
            v = v * m + f;
        end
        return v;
    endfunction

    function automatic logic [31:0] int2pk(input int v, input int d, input int w, input int m);
        logic [31:0] p = '0;
        for (int i = 0; i < d; i++) begin
            p = p | (32'(v % m) << (i * w));
            v = v / m;
        end
        return p;
    endfunction

    task automatic model_step(inout int v, inout bit w, input bit en, input bit up,
                              input bit clr, input bit load, input logic [31:0] lv,
                              input int d, input int wd, input int m, input int modv);
        w = 1'b0;
        if (clr) v = 0;
        else if (load) v = pk2int(lv, d, wd, m);
        else if (en) begin
            if (up) begin w = (v == modv - 1); v = (v + 1) % modv; end
            else    begin w = (v == 0);        v = (v + modv - 1) % modv; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply stimulus, check tc before the edge, clock, then check out/wrap.
    task automatic tick();
        bit etc_a, etc_b;
        a_if.en = a_en; a_if.up = a_up; a_if.clr = a_clr; a_if.load = a_load;
        a_if.load_val = a_lv[AD*AW-1:0];
        b_if.en = b_en; b_if.up = b_up; b_if.clr = b_clr; b_if.load = b_load;
        b_if.load_val = b_lv[BD*BW-1:0];
        #1;
        etc_a = a_en && (a_up ? (a_v == AMOD - 1) : (a_v == 0));
        etc_b = b_en && (b_up ? (b_v == BMOD - 1) : (b_v == 0));
        check("a_tc", 32'(a_if.tc), 32'(etc_a));
        check("b_tc", 32'(b_if.tc), 32'(etc_b));
        @(posedge clk);
        model_step(a_v, a_w, a_en, a_up, a_clr, a_load, a_lv, AD, AW, AM, AMOD);
        model_step(b_v, b_w, b_en, b_up, b_clr, b_load, b_lv, BD, BW, BM, BMOD);
        #1;
        check("a_out",  32'(a_if.out),  int2pk(a_v, AD, AW, AM));
        check("a_wrap", 32'(a_if.wrap), 32'(a_w));
        check("b_out",  32'(b_if.out),  int2pk(b_v, BD, BW, BM));
        check("b_wrap", 32'(b_if.wrap), 32'(b_w));
    endtask

    task automatic a_set(input bit en, input bit up, input bit clr, input bit load,
                         input logic [31:0] lv);
        a_en = en; a_up = up; a_clr = clr; a_load = load; a_lv = lv;
    endtask

    task automatic b_set(input bit en, input bit up, input bit clr, input bit load,
                         input logic [31:0] lv);
        b_en = en; b_up = up; b_clr = clr; b_load = load; b_lv = lv;
    endtask

    initial begin
        a_set(0, 1, 0, 0, 0);
        b_set(0, 1, 0, 0, 0);
        a_if.en = 0; a_if.up = 1; a_if.clr = 0; a_if.load = 0; a_if.load_val = '0;
        b_if.en = 0; b_if.up = 1; b_if.clr = 0; b_if.load = 0; b_if.load_val = '0;
        a_v = 0; b_v = 0; a_w = 0; b_w = 0;
        rst = 1'b1;
        #2;
        check("rst_a_out",  32'(a_if.out),  32'h0);
        check("rst_a_wrap", 32'(a_if.wrap), 32'h0);
        check("rst_b_out",  32'(b_if.out),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Count up through the full 00..99 range and wrap once.
        a_set(1, 1, 0, 0, 0);
        for (int i = 0; i < 101; i++) tick();

        // Down from 01 -> 00 -> 99 -> 98 -> 97.
        a_set(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();

        // Borrow across digits: 90 -> 89.
        a_set(0, 0, 0, 1, 32'h90); tick();
        a_set(1, 0, 0, 0, 0);      tick();

        // Load beats en; saturating load.
        a_set(1, 1, 0, 1, 32'h37); tick();
        a_set(0, 1, 0, 1, 32'hC5); tick();

        // Load 99 then clr+load+en with tc high: clear wins, no wrap.
        a_set(0, 1, 0, 1, 32'h99); tick();
        a_set(1, 1, 1, 1, 32'h42); tick();
        a_set(0, 1, 0, 1, 32'h42); tick();
        a_set(1, 1, 1, 1, 32'h55); tick();
        a_set(0, 1, 0, 1, 32'h42); tick();
        a_set(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();

        // Asynchronous reset mid-cycle at 58.
        a_set(0, 1, 0, 1, 32'h58); tick();
        a_set(1, 1, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_a_out",  32'(a_if.out),  32'h0);
        check("arst_a_wrap", 32'(a_if.wrap), 32'h0);
        a_v = 0; b_v = 0; a_w = 0; b_w = 0;
        #2 rst = 1'b0;
        tick();
        check("post_rst_a", 32'(a_if.out), 32'h01);

        // 3-digit hex chain: FFF -> 000 up, then FFF down, each with a wrap pulse.
        a_set(0, 1, 0, 0, 0);
        b_set(0, 1, 0, 1, 32'hFFF); tick();
        b_set(1, 1, 0, 0, 0);       tick();
        check("b_up_wrap", 32'(b_if.out), 32'h000);
        b_set(1, 0, 0, 0, 0);       tick();
        check("b_dn_wrap", 32'(b_if.out), 32'hFFF);
        b_set(1, 0, 0, 0, 0);       tick();

        // Randomized mix on both chains.
        for (int i = 0; i < 400; i++) begin
            a_set($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0, $urandom);
            b_set($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0, $urandom);
            // Steer toward boundaries now and then so wrap/tc are exercised.
            if ($urandom_range(0, 9) == 0) a_set(0, 1, 0, 1, $urandom_range(0, 1) ? 32'h99 : 32'h00);
            if ($urandom_range(0, 9) == 0) b_set(0, 1, 0, 1, $urandom_range(0, 1) ? 32'hFFF : 32'h000);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_counter_chain.md
# mod_counter_chain

Parametrised cascade of DIGITS modulo-MAX digit counters sharing one clock, with up/down direction, synchronous load, synchronous clear, and chain-level terminal-count and wrap indications. It is the multi-digit, bidirectional successor of the single-digit modulo counter. It feeds display/timekeeping logic that needs packed decimal (or any radix) counts and an overflow strobe for cascading further chains.

## Interface
- DIGITS, default 4: number of cascaded digits; ≥1.
- WIDTH, default 4: bits per digit; 2^WIDTH ≥ MAX.
- MAX, default 10: digit modulus; each digit counts 0..MAX-1; ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; advances chain by one step per cycle when high.
- up  in  1  direction; 1 = increment, 0 = decrement; sampled every cycle.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  DIGITS*WIDTH  packed load value; digit i at bits [i*WIDTH +: WIDTH], digit 0 least significant.
- out  out  DIGITS*WIDTH  packed registered count, same packing as load_val.
- tc  out  1  combinational terminal count: en & all digits at MAX-1 (up) or all 0 (down).
- wrap  out  1  registered one-cycle pulse: chain wrapped on the previous edge.

## Operation
- Priority per cycle: clr > load > en > hold.
- clr: all digits ← 0; wrap ← 0.
- load: digit i ← load_val digit i; any field ≥ MAX saturates to MAX-1; wrap ← 0.
- en, up=1: digit 0 increments; digit i increments when all lower digits = MAX-1; a digit at MAX-1 that increments becomes 0.
- en, up=0: digit 0 decrements; digit i decrements when all lower digits = 0; a digit at 0 that decrements becomes MAX-1.
- Carry/borrow ripples combinationally through all digits in the same cycle; every digit updates on the same edge.
- wrap ← tc on every enabled step; all-(MAX-1)→all-0 (up) or all-0→all-(MAX-1) (down).
- en=0, clr=0, load=0: out holds; wrap ← 0.
- Direction change takes effect on the step where it is sampled; no extra latency.
- Digit arithmetic is WIDTH-bit unsigned; no value ≥ MAX is ever stored.

## Timing
- Reset: out = 0, wrap = 0, asserted immediately on rst rise, independent of clk.
- Reset release: first step occurs on the first rising edge with rst low and en high.
- Reset mid-count discards the count; no wrap pulse is produced for the interrupted step.
- Latency: en/clr/load sampled at edge N → out valid after edge N; wrap valid for exactly cycle N→N+1.
- tc has zero latency, for cascading to a further chain's en input.
- Simultaneous clr+load+en: clear wins; tc may be high that cycle but wrap stays 0.

## Structure
- Shared package/header: direction constants DIR_UP=1, DIR_DOWN=0; digit-field macro/function for packed indexing.
- Sub-module counter_digit, instantiated DIGITS times via generate:
  - inputs: clk, rst, step, up, clr, load, load digit.
  - outputs: digit value, at_max, at_zero.
  - parameters WIDTH, MAX.
- Top level: carry/borrow AND-chain, tc, and the wrap register.

## Test plan
- DIGITS=2, MAX=10, up=1, en continuous from reset: out counts 00..99. On the edge after 99, out=00; wrap=1 for exactly one cycle; tc=1 only while out=99.
- up=0 from 00: next out=99 with wrap pulse; then 98, 97. Borrow check: 90→89.
- load_val=0x37 with load=1, en=1: out=0x37 next cycle, no increment. load_val=0xC5 → out=0x95 (saturate).
- clr=1, load=1, en=1 at out=0x42: out=0x00, wrap=0. en=0 for 5 cycles: out holds.
- Assert rst asynchronously mid-cycle at out=0x58: out=0, wrap=0 before next edge. After release, first step gives 0x01.
- DIGITS=3, MAX=16, WIDTH=4, load 0xFFF, up=1: next out=0x000, wrap pulse. Toggle up=0 the next cycle: out=0xFFF, wrap pulse.
